// File: rtl/ctrl_seq_pkg.sv
// Shared types and constants for the hardwired control-step sequencers.
package ctrl_seq_pkg;

  // Control steps of one fetch/execute pass.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_T0,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_T4,
    ST_T5,
    ST_T6,
    ST_DONE
  } state_e;

  // What kind of execute sequence an opcode needs.
  typedef enum logic [1:0] {
    CLS_ALU,
    CLS_MULDIV,
    CLS_NOP,
    CLS_ILLEGAL
  } op_class_e;

  // Opcode encodings.
  localparam logic [4:0] OPC_ADD = 5'b00011;
  localparam logic [4:0] OPC_AND = 5'b00101;
  localparam logic [4:0] OPC_OR  = 5'b00110;
  localparam logic [4:0] OPC_SUB = 5'b00100;
  localparam logic [4:0] OPC_MUL = 5'b01111;
  localparam logic [4:0] OPC_DIV = 5'b10000;
  localparam logic [4:0] OPC_NOP = 5'b11010;

  // One-hot ALU operation selects; INC is only used by the PC increment in T0.
  localparam logic [7:0] ALU_NONE = 8'h00;
  localparam logic [7:0] ALU_ADD  = 8'h01;
  localparam logic [7:0] ALU_AND  = 8'h02;
  localparam logic [7:0] ALU_OR   = 8'h04;
  localparam logic [7:0] ALU_SUB  = 8'h08;
  localparam logic [7:0] ALU_MUL  = 8'h10;
  localparam logic [7:0] ALU_DIV  = 8'h20;
  localparam logic [7:0] ALU_INC  = 8'h40;

  // Most-significant bit of each IR field; fields extend downward from here.
  localparam int IR_OPC_MSB = 31;
  localparam int IR_RA_MSB  = 26;
  localparam int IR_RB_MSB  = 22;
  localparam int IR_RC_MSB  = 18;

endpackage

// File: rtl/ctrl_opcode_decoder.sv
// Combinational opcode classifier shared by the control-step sequencers.
module ctrl_opcode_decoder
  import ctrl_seq_pkg::*;
#(
  parameter int OPC_W      = 5,
  parameter int ALU_CTRL_W = 8
) (
  input  logic [OPC_W-1:0]      opcode,
  output op_class_e             op_class,
  output logic [ALU_CTRL_W-1:0] alu_ctrl
);

  // Map the opcode to its execute class and ALU select; unknown opcodes are illegal.
  always_comb begin
    op_class = CLS_ILLEGAL;
    alu_ctrl = ALU_CTRL_W'(ALU_NONE);
    case (opcode)
      OPC_W'(OPC_ADD): begin op_class = CLS_ALU;    alu_ctrl = ALU_CTRL_W'(ALU_ADD); end
      OPC_W'(OPC_AND): begin op_class = CLS_ALU;    alu_ctrl = ALU_CTRL_W'(ALU_AND); end
      OPC_W'(OPC_OR):  begin op_class = CLS_ALU;    alu_ctrl = ALU_CTRL_W'(ALU_OR);  end
      OPC_W'(OPC_SUB): begin op_class = CLS_ALU;    alu_ctrl = ALU_CTRL_W'(ALU_SUB); end
      OPC_W'(OPC_MUL): begin op_class = CLS_MULDIV; alu_ctrl = ALU_CTRL_W'(ALU_MUL); end
      OPC_W'(OPC_DIV): begin op_class = CLS_MULDIV; alu_ctrl = ALU_CTRL_W'(ALU_DIV); end
      OPC_W'(OPC_NOP): begin op_class = CLS_NOP; end
      default: ;
    endcase
  end

endmodule

// File: rtl/ctrl_step_sequencer.sv
// Hardwired T0..T6 control-step sequencer for the 32-bit bus datapath:
// fetch with a memory-ready handshake and timeout, then execute of ALU and MUL/DIV ops.
module ctrl_step_sequencer
  import ctrl_seq_pkg::*;
#(
  parameter int NUM_REGS    = 16,
  parameter int REG_IDX_W   = 4,
  parameter int OPC_W       = 5,
  parameter int ALU_CTRL_W  = 8,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  start,
  input  logic [31:0]           ir,
  input  logic                  mem_ready,
  output logic                  PCout,
  output logic                  MARin,
  output logic                  IncPC,
  output logic                  Zin,
  output logic                  Zlowout,
  output logic                  Zhighout,
  output logic                  PCin,
  output logic                  read,
  output logic                  MDRin,
  output logic                  MDRout,
  output logic                  IRin,
  output logic                  Yin,
  output logic                  HIin,
  output logic                  LOin,
  output logic [NUM_REGS-1:0]   Rin,
  output logic [NUM_REGS-1:0]   Rout,
  output logic [ALU_CTRL_W-1:0] ALU_control,
  output logic                  busy,
  output logic                  done,
  output logic                  illegal,
  output logic                  timeout
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_e                  state, state_nxt;
  logic [WAIT_W-1:0]       wait_cnt, wait_cnt_nxt;
  logic                    illegal_q, illegal_nxt;
  logic                    timeout_q, timeout_nxt;

  logic [OPC_W-1:0]        opcode;
  logic [REG_IDX_W-1:0]    ra, rb, rc;
  op_class_e               op_class;
  logic [ALU_CTRL_W-1:0]   alu_sel;
  logic                    unused_ir_bits;

  assign opcode         = ir[IR_OPC_MSB -: OPC_W];
  assign ra             = ir[IR_RA_MSB -: REG_IDX_W];
  assign rb             = ir[IR_RB_MSB -: REG_IDX_W];
  assign rc             = ir[IR_RC_MSB -: REG_IDX_W];
  assign unused_ir_bits = ^ir[IR_RC_MSB-REG_IDX_W:0];

  function automatic logic [NUM_REGS-1:0] reg_sel(input logic [REG_IDX_W-1:0] idx);
    reg_sel = NUM_REGS'(1) << idx;
  endfunction

  ctrl_opcode_decoder #(
    .OPC_W      (OPC_W),
    .ALU_CTRL_W (ALU_CTRL_W)
  ) u_decoder (
    .opcode   (opcode),
    .op_class (op_class),
    .alu_ctrl (alu_sel)
  );

  // State register plus the T1 wait counter and the flags reported in DONE.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      illegal_q <= illegal_nxt;
      timeout_q <= timeout_nxt;
    end
  end

  // Step sequencing; the wait counter only advances while T1 is stalled on memory.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = '0;
    illegal_nxt  = 1'b0;
    timeout_nxt  = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_T0;
      ST_T0:   state_nxt = ST_T1;
      ST_T1: begin
        if (mem_ready) begin
          state_nxt = ST_T2;
        end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
          state_nxt   = ST_DONE;
          timeout_nxt = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      ST_T2:   state_nxt = ST_T3;
      ST_T3: begin
        case (op_class)
          CLS_NOP:     state_nxt = ST_DONE;
          CLS_ILLEGAL: begin
            state_nxt   = ST_DONE;
            illegal_nxt = 1'b1;
          end
          default:     state_nxt = ST_T4;
        endcase
      end
      ST_T4:   state_nxt = ST_T5;
      ST_T5:   state_nxt = (op_class == CLS_MULDIV) ? ST_T6 : ST_DONE;
      ST_T6:   state_nxt = ST_DONE;
      ST_DONE: state_nxt = start ? ST_T0 : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Moore strobe decode; clear also gates the decode so nothing can pulse while the state is being forced.
  always_comb begin
    PCout       = 1'b0;
    MARin       = 1'b0;
    IncPC       = 1'b0;
    Zin         = 1'b0;
    Zlowout     = 1'b0;
    Zhighout    = 1'b0;
    PCin        = 1'b0;
    read        = 1'b0;
    MDRin       = 1'b0;
    MDRout      = 1'b0;
    IRin        = 1'b0;
    Yin         = 1'b0;
    HIin        = 1'b0;
    LOin        = 1'b0;
    Rin         = '0;
    Rout        = '0;
    ALU_control = ALU_CTRL_W'(ALU_NONE);
    busy        = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    timeout     = 1'b0;
    if (!clear) begin
      busy = (state != ST_IDLE);
      case (state)
        ST_T0: begin
          PCout       = 1'b1;
          MARin       = 1'b1;
          IncPC       = 1'b1;
          Zin         = 1'b1;
          ALU_control = ALU_CTRL_W'(ALU_INC);
        end
        ST_T1: begin
          Zlowout = 1'b1;
          read    = 1'b1;
          MDRin   = 1'b1;
          PCin    = (wait_cnt == '0);
        end
        ST_T2: begin
          MDRout = 1'b1;
          IRin   = 1'b1;
        end
        ST_T3: begin
          if (op_class == CLS_ALU || op_class == CLS_MULDIV) begin
            Rout = reg_sel(rb);
            Yin  = 1'b1;
          end
        end
        ST_T4: begin
          Rout        = reg_sel(rc);
          Zin         = 1'b1;
          ALU_control = alu_sel;
        end
        ST_T5: begin
          Zlowout = 1'b1;
          if (op_class == CLS_MULDIV) begin
            LOin = 1'b1;
          end else if (op_class == CLS_ALU) begin
            Rin = reg_sel(ra);
          end
        end
        ST_T6: begin
          Zhighout = 1'b1;
          HIin     = 1'b1;
        end
        ST_DONE: begin
          done    = 1'b1;
          illegal = illegal_q;
          timeout = timeout_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_step_sequencer.sv
// Directed self-checking bench for ctrl_step_sequencer.
// Cycle 1 is the T0 cycle that follows the edge sampling start.
module tb_ctrl_step_sequencer;

  logic        clock_tb;
  logic        clear;
  logic        start;
  logic [31:0] ir;
  logic        mem_ready;

  logic        pc_out, mar_in, inc_pc, z_in, zlow_out, zhigh_out, pc_in;
  logic        rd, mdr_in, mdr_out, ir_in, y_in, hi_in, lo_in;
  logic [15:0] r_in, r_out;
  logic [7:0]  alu_control;
  logic        busy, done, illegal, timeout;
  logic [57:0] all_outs;

  int tests_run    = 0;
  int tests_failed = 0;

  localparam logic [31:0] IR_AND     = 32'h2A2B8000;
  localparam logic [31:0] IR_MUL     = {5'b01111, 4'd2, 4'd3, 4'd7, 15'd0};
  localparam logic [31:0] IR_ADD     = {5'b00011, 4'd1, 4'd2, 4'd3, 15'd0};
  localparam logic [31:0] IR_ILLEGAL = 32'hF8000000;
  localparam logic [31:0] IR_NOP     = 32'hD0000000;

  assign all_outs = {pc_out, mar_in, inc_pc, z_in, zlow_out, zhigh_out, pc_in, rd, mdr_in,
                     mdr_out, ir_in, y_in, hi_in, lo_in, r_in, r_out, alu_control,
                     busy, done, illegal, timeout};

  ctrl_step_sequencer dut (
    .clock       (clock_tb),
    .clear       (clear),
    .start       (start),
    .ir          (ir),
    .mem_ready   (mem_ready),
    .PCout       (pc_out),
    .MARin       (mar_in),
    .IncPC       (inc_pc),
    .Zin         (z_in),
    .Zlowout     (zlow_out),
    .Zhighout    (zhigh_out),
    .PCin        (pc_in),
    .read        (rd),
    .MDRin       (mdr_in),
    .MDRout      (mdr_out),
    .IRin        (ir_in),
    .Yin         (y_in),
    .HIin        (hi_in),
    .LOin        (lo_in),
    .Rin         (r_in),
    .Rout        (r_out),
    .ALU_control (alu_control),
    .busy        (busy),
    .done        (done),
    .illegal     (illegal),
    .timeout     (timeout)
  );

  // Free-running 100 MHz clock.
  initial begin
    clock_tb = 1'b0;
    forever #5 clock_tb = ~clock_tb;
  end

  task automatic tick();
    @(posedge clock_tb);
    #1;
  endtask

  // Pulse start for one edge; returns in cycle 1 (T0).
  task automatic launch(input logic [31:0] ir_v, input logic mr);
    ir        = ir_v;
    mem_ready = mr;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b1;
    #3;
    tests_run++;
    if (all_outs !== 58'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", all_outs);
    end
    tick();
    tick();
    clear = 1'b0;
    tick();
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_idle: busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_and();
    launch(IR_AND, 1'b1);
    tests_run++;
    if ({pc_out, mar_in, inc_pc, z_in, alu_control, busy} !== {4'b1111, 8'h40, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL and_t0: got %b/%h expected 1111/40", {pc_out, mar_in, inc_pc, z_in}, alu_control);
    end
    tick();
    tests_run++;
    if ({zlow_out, pc_in, rd, mdr_in} !== 4'b1111) begin
      tests_failed++;
      $display("[TB] FAIL and_t1: got %b expected 1111", {zlow_out, pc_in, rd, mdr_in});
    end
    tick();
    tests_run++;
    if ({mdr_out, ir_in} !== 2'b11) begin
      tests_failed++;
      $display("[TB] FAIL and_t2: got %b expected 11", {mdr_out, ir_in});
    end
    tick();
    tests_run++;
    if (r_out !== 16'h0020 || y_in !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL and_t3: Rout=%h Yin=%b expected 0020 1", r_out, y_in);
    end
    tick();
    tests_run++;
    if (r_out !== 16'h0080 || alu_control !== 8'h02 || z_in !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL and_t4: Rout=%h alu=%h Zin=%b expected 0080 02 1", r_out, alu_control, z_in);
    end
    tick();
    tests_run++;
    if (r_in !== 16'h0010 || zlow_out !== 1'b1 || done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL and_t5: Rin=%h Zlowout=%b done=%b expected 0010 1 0", r_in, zlow_out, done);
    end
    tick();
    tests_run++;
    if ({done, illegal, timeout} !== 3'b100) begin
      tests_failed++;
      $display("[TB] FAIL and_done_c7: got %b expected 100", {done, illegal, timeout});
    end
    tick();
    tests_run++;
    if ({busy, done} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL and_idle_after: busy/done=%b expected 00", {busy, done});
    end
  endtask

  task automatic test_mul();
    int done_cycle = 0;
    logic rin_seen = 1'b0;
    launch(IR_MUL, 1'b1);
    for (int c = 1; c <= 10; c++) begin
      if (r_in !== 16'h0) rin_seen = 1'b1;
      if (done === 1'b1 && done_cycle == 0) done_cycle = c;
      if (c == 4) begin
        tests_run++;
        if (r_out !== 16'h0008 || y_in !== 1'b1) begin
          tests_failed++;
          $display("[TB] FAIL mul_t3: Rout=%h Yin=%b expected 0008 1", r_out, y_in);
        end
      end
      if (c == 5) begin
        tests_run++;
        if (r_out !== 16'h0080 || alu_control !== 8'h10) begin
          tests_failed++;
          $display("[TB] FAIL mul_t4: Rout=%h alu=%h expected 0080 10", r_out, alu_control);
        end
      end
      if (c == 6) begin
        tests_run++;
        if ({lo_in, zlow_out, hi_in, zhigh_out} !== 4'b1100) begin
          tests_failed++;
          $display("[TB] FAIL mul_t5: LO/Zlo/HI/Zhi=%b expected 1100", {lo_in, zlow_out, hi_in, zhigh_out});
        end
      end
      if (c == 7) begin
        tests_run++;
        if ({hi_in, zhigh_out, lo_in, zlow_out} !== 4'b1100) begin
          tests_failed++;
          $display("[TB] FAIL mul_t6: HI/Zhi/LO/Zlo=%b expected 1100", {hi_in, zhigh_out, lo_in, zlow_out});
        end
      end
      tick();
    end
    tests_run++;
    if (done_cycle != 8) begin
      tests_failed++;
      $display("[TB] FAIL mul_latency: done cycle %0d expected 8", done_cycle);
    end
    tests_run++;
    if (rin_seen !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL mul_rin_zero: Rin seen=%b expected 0", rin_seen);
    end
  endtask

  task automatic test_mem_wait();
    int read_cnt = 0, pcin_cnt = 0, pcin_cycle = 0, done_cycle = 0;
    logic [7:0] alu_t4 = 8'h00;
    launch(IR_ADD, 1'b0);
    for (int c = 1; c <= 13; c++) begin
      mem_ready = (c >= 5);
      if (rd === 1'b1 && mdr_in === 1'b1) read_cnt++;
      if (pc_in === 1'b1) begin
        pcin_cnt++;
        pcin_cycle = c;
      end
      if (z_in === 1'b1 && pc_out === 1'b0) alu_t4 = alu_control;
      if (done === 1'b1 && done_cycle == 0) done_cycle = c;
      tick();
    end
    tests_run++;
    if (read_cnt != 4) begin
      tests_failed++;
      $display("[TB] FAIL wait_read_cycles: got %0d expected 4", read_cnt);
    end
    tests_run++;
    if (pcin_cnt != 1 || pcin_cycle != 2) begin
      tests_failed++;
      $display("[TB] FAIL wait_pcin: count %0d at cycle %0d expected 1 at 2", pcin_cnt, pcin_cycle);
    end
    tests_run++;
    if (alu_t4 !== 8'h01) begin
      tests_failed++;
      $display("[TB] FAIL wait_add_alu: got %h expected 01", alu_t4);
    end
    tests_run++;
    if (done_cycle != 10) begin
      tests_failed++;
      $display("[TB] FAIL wait_latency: done cycle %0d expected 10", done_cycle);
    end
  endtask

  task automatic test_timeout();
    int read_cnt = 0, done_cycle = 0, to_cnt = 0;
    logic irin_seen = 1'b0;
    logic to_at_done = 1'b0;
    logic busy_after = 1'b1;
    launch(IR_ADD, 1'b0);
    for (int c = 1; c <= 22; c++) begin
      if (rd === 1'b1) read_cnt++;
      if (ir_in === 1'b1) irin_seen = 1'b1;
      if (timeout === 1'b1) to_cnt++;
      if (done === 1'b1 && done_cycle == 0) begin
        done_cycle = c;
        to_at_done = timeout;
      end
      if (c == 18) busy_after = busy;
      tick();
    end
    tests_run++;
    if (done_cycle != 17 || to_at_done !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL timeout_done: done cycle %0d timeout %b expected 17 1", done_cycle, to_at_done);
    end
    tests_run++;
    if (read_cnt != 15 || to_cnt != 1) begin
      tests_failed++;
      $display("[TB] FAIL timeout_counts: read %0d pulses %0d expected 15 1", read_cnt, to_cnt);
    end
    tests_run++;
    if (irin_seen !== 1'b0 || busy_after !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL timeout_abort: IRin seen %b busy after %b expected 0 0", irin_seen, busy_after);
    end
  endtask

  task automatic test_illegal();
    launch(IR_ILLEGAL, 1'b1);
    tick();
    tick();
    tick();
    tests_run++;
    if (r_out !== 16'h0 || y_in !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL illegal_t3: Rout=%h Yin=%b expected 0000 0", r_out, y_in);
    end
    tick();
    tests_run++;
    if ({done, illegal, timeout} !== 3'b110) begin
      tests_failed++;
      $display("[TB] FAIL illegal_done_c5: got %b expected 110", {done, illegal, timeout});
    end
    tick();
    tests_run++;
    if ({busy, illegal} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL illegal_after: busy/illegal=%b expected 00", {busy, illegal});
    end
  endtask

  task automatic test_nop();
    launch(IR_NOP, 1'b1);
    tick();
    tick();
    tick();
    tests_run++;
    if (y_in !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL nop_t3: Yin=%b done=%b expected 0 0", y_in, done);
    end
    tick();
    tests_run++;
    if ({done, illegal, timeout} !== 3'b100) begin
      tests_failed++;
      $display("[TB] FAIL nop_done_c5: got %b expected 100", {done, illegal, timeout});
    end
    tick();
  endtask

  task automatic test_clear_mid();
    int done_cycle = 0;
    launch(IR_AND, 1'b1);
    tick();
    tick();
    tick();
    tick();
    tests_run++;
    if (z_in !== 1'b1 || r_out !== 16'h0080) begin
      tests_failed++;
      $display("[TB] FAIL clear_pre_t4: Zin=%b Rout=%h expected 1 0080", z_in, r_out);
    end
    #2;
    clear = 1'b1;
    #1;
    tests_run++;
    if (all_outs !== 58'd0) begin
      tests_failed++;
      $display("[TB] FAIL clear_async: got %h expected 0", all_outs);
    end
    tick();
    clear = 1'b0;
    tick();
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL clear_idle: busy=%b expected 0", busy);
    end
    launch(IR_AND, 1'b1);
    tests_run++;
    if (all_outs !== {4'b1111, 10'b0, 16'h0, 16'h0, 8'h40, 4'b1000}) begin
      tests_failed++;
      $display("[TB] FAIL clear_restart_t0: got %h expected clean T0", all_outs);
    end
    for (int c = 1; c <= 10; c++) begin
      if (done === 1'b1 && done_cycle == 0) done_cycle = c;
      tick();
    end
    tests_run++;
    if (done_cycle != 7) begin
      tests_failed++;
      $display("[TB] FAIL clear_restart_latency: done cycle %0d expected 7", done_cycle);
    end
  endtask

  task automatic test_back_to_back();
    int first_done = 0, second_done = 0;
    logic busy_end = 1'b1;
    ir        = IR_NOP;
    mem_ready = 1'b1;
    start     = 1'b1;
    tick();
    for (int c = 1; c <= 12; c++) begin
      start = (c <= 5);
      if (done === 1'b1) begin
        if (first_done == 0) first_done = c;
        else if (second_done == 0) second_done = c;
      end
      if (c == 11) busy_end = busy;
      tick();
    end
    tests_run++;
    if (first_done != 5 || second_done != 10) begin
      tests_failed++;
      $display("[TB] FAIL b2b_done_cycles: got %0d,%0d expected 5,10", first_done, second_done);
    end
    tests_run++;
    if (busy_end !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_idle: busy=%b expected 0", busy_end);
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    clear     = 1'b0;
    start     = 1'b0;
    ir        = 32'h0;
    mem_ready = 1'b0;
    #2;
    test_reset();
    test_and();
    test_mul();
    test_mem_wait();
    test_timeout();
    test_illegal();
    test_nop();
    test_clear_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ctrl_step_sequencer.md
Name: ctrl_step_sequencer

Overview:
Hardwired control-step sequencer that generates the T0..Tn control strobes for the 32-bit bus datapath.
- Covers instruction fetch and execute of register-register ALU ops, plus MUL/DIV ops that write LO/HI.
- Replaces hand-driven per-instruction control sequences.
- Register count, opcode width and ALU control width are parametrised.
- Adds a memory-ready handshake with timeout, and illegal-opcode detection.

Parameters:
- NUM_REGS, 16, number of general registers; width of the Rin/Rout one-hot vectors.
- REG_IDX_W, 4, register field width in IR; must equal $clog2(NUM_REGS).
- OPC_W, 5, opcode field width at IR[31:32-OPC_W].
- ALU_CTRL_W, 8, width of the one-hot ALU_control output.
- MEM_TIMEOUT, 15, maximum cycles T1 waits for mem_ready before aborting.

Ports:
- clock, in, 1: system clock, rising edge.
- clear, in, 1: asynchronous reset, active-high.
- start, in, 1: begin fetch/execute; sampled in IDLE and DONE only.
- ir, in, 32: IR register contents, valid from T3 onward.
- mem_ready, in, 1: memory data valid on Mdatain.
- PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, read, MDRin, MDRout, IRin, Yin, HIin, LOin: out, 1 each: datapath strobes.
- Rin, out, NUM_REGS: one-hot register load enables.
- Rout, out, NUM_REGS: one-hot register bus drives.
- ALU_control, out, ALU_CTRL_W: one-hot ALU operation select.
- busy, out, 1: high in any state other than IDLE.
- done, out, 1: one-cycle pulse on completion.
- illegal, out, 1: one-cycle pulse, concurrent with done, for an undefined opcode.
- timeout, out, 1: one-cycle pulse, concurrent with done, on memory timeout.

Behaviour:
- Reset: clock domain is clock only; reset is asynchronous, active-high (clear). clear forces state IDLE, the wait counter to 0, and every output to 0. This holds mid-operation; no strobe may glitch high after clear rises.
- Strobes are Moore outputs decoded from the state register. Exception: in T1, read and MDRin are held high while waiting.
- IR fields: opcode IR[31:27], ra (destination) IR[26:23], rb IR[22:19], rc IR[18:15].
- Opcode classes:
  - ADD 00011 -> ALU_control 0x01
  - AND 00101 -> 0x02
  - OR 00110 -> 0x04
  - SUB 00100 -> 0x08
  - MUL 01111 -> 0x10
  - DIV 10000 -> 0x20
  - NOP 11010
  - all other opcodes are illegal
  - ALU_control is 0x00 in states that do not use the ALU.
- State sequence:
  - IDLE: start=1 -> T0.
  - T0: PCout, MARin, IncPC, Zin, ALU_control=0x40 (INC). Next T1.
  - T1: Zlowout, PCin, read, MDRin.
    - mem_ready=1 -> T2.
    - Otherwise stay in T1 and increment the wait counter. PCin is asserted only in the first T1 cycle.
    - Counter reaching MEM_TIMEOUT -> DONE with timeout=1.
  - T2: MDRout, IRin. Next T3.
  - T3: decode the ir input.
    - NOP -> DONE.
    - Illegal -> DONE with illegal=1.
    - Otherwise assert Rout[rb] and Yin, then go to T4.
  - T4: Rout[rc], Zin, ALU_control per opcode. Next T5.
  - T5:
    - ALU class: Zlowout, Rin[ra], then DONE.
    - MUL/DIV: Zlowout, LOin, then T6.
  - T6: Zhighout, HIin. Next DONE.
  - DONE: done=1 for one cycle. start=1 -> T0 (back-to-back); otherwise IDLE.
- Latency from the start edge to the done cycle, with mem_ready already high in T1:
  - ALU class: 7 cycles.
  - MUL/DIV: 8 cycles.
  - NOP and illegal: 5 cycles.
  - Each extra T1 wait cycle adds 1.
- Bus ownership:
  - At most one of PCout, Zlowout, Zhighout, MDRout, or any Rout bit is high in any cycle.
  - Rin and Rout are one-hot or all zero.
- start asserted in states T0..T6 is ignored, not queued.
- rb==rc is legal. ra equal to rb or rc is legal; ra is written only in T5.
- mem_ready high outside T1 is ignored.

Decomposition:
- Package ctrl_seq_pkg holds:
  - the state enum (IDLE, T0..T6, DONE)
  - opcode constants
  - ALU_control one-hot constants, including INC
  - IR field bit positions
  - the op-class enum (ALU, MULDIV, NOP, ILLEGAL)
- Sub-module ctrl_opcode_decoder: purely combinational; maps opcode to {op class, ALU_control}. It is reused later by the shift/immediate sequencers.

Test Plan:
- Reset and AND: clear pulse, then start with mem_ready=1 and ir=0x2A2B8000 (AND, ra=4, rb=5, rc=7).
  - T3: Rout=0x0020 and Yin.
  - T4: Rout=0x0080 and ALU_control=0x02.
  - T5: Rin=0x0010.
  - done is high 7 cycles after start.
- MUL: ir opcode 01111 with rb=3, rc=7.
  - T5: LOin and Zlowout.
  - T6: HIin and Zhighout.
  - done at cycle 8; Rin stays 0 throughout.
- Memory wait: mem_ready held low for 3 cycles in T1.
  - read and MDRin stay high for 4 cycles; PCin is high only in the first.
  - done at cycle 10.
- Timeout: mem_ready never asserted -> after 15 wait cycles, done=1 and timeout=1, then IDLE; IRin never asserted.
- Illegal opcode (ir=0xF8000000) -> at T3 no Rout; done=1 and illegal=1 at cycle 5.
- Async clear during T4 -> all outputs 0 immediately, without waiting for a clock edge. busy=0. A new start then runs a clean T0.
